// File: rtl/hvpi_nested_ctrl.sv
// Vectored, nested, fixed-priority interrupt controller.
// Captures N sources (edge or level per source), masks them, resolves the
// highest-priority eligible source above the current in-service level and
// presents its ISR address to the CPU through a pending/ack handshake.
module hvpi_nested_ctrl #(
  parameter int unsigned          NUM_INTS        = 8,
  parameter int unsigned          PC_WIDTH        = 16,
  parameter logic [PC_WIDTH-1:0]  VEC_BASE        = '0,
  parameter int unsigned          VEC_STRIDE_LOG2 = 2,
  parameter logic [NUM_INTS-1:0]  EDGE_MASK       = '1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_INTS-1:0]                      ints,
  input  logic [NUM_INTS-1:0]                      mask_in,
  input  logic                                     ld_mask,
  input  logic                                     clr_mask,
  input  logic                                     int_disable,
  input  logic                                     int_ack,
  input  logic                                     isr_done,
  output logic                                     int_pending,
  output logic [PC_WIDTH-1:0]                      int_addr,
  output logic [((NUM_INTS > 1) ? $clog2(NUM_INTS) : 1)-1:0] int_id,
  output logic [NUM_INTS-1:0]                      in_service
);

  localparam int unsigned IdW = (NUM_INTS > 1) ? $clog2(NUM_INTS) : 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } ctrlState_e;

  ctrlState_e            state;
  ctrlState_e            stateNext;

  logic [NUM_INTS-1:0]   pend;
  logic [NUM_INTS-1:0]   pendNext;
  logic [NUM_INTS-1:0]   maskReg;
  logic [NUM_INTS-1:0]   maskNext;
  logic [NUM_INTS-1:0]   intsPrev;
  logic [NUM_INTS-1:0]   inServiceNext;

  logic [NUM_INTS-1:0]   prioOk;
  logic [NUM_INTS-1:0]   elig;
  logic                  anyElig;
  logic [IdW-1:0]        winId;
  logic [PC_WIDTH-1:0]   winAddr;

  logic                  ackFire;
  logic                  pendingNext;
  logic [IdW-1:0]        idNext;
  logic [PC_WIDTH-1:0]   addrNext;

  // A source may preempt only if no in-service bit sits at or above its priority
  always_comb begin
    logic seen;
    seen   = 1'b0;
    prioOk = '0;
    for (int i = 0; i < int'(NUM_INTS); i++) begin
      seen      = seen | in_service[i];
      prioOk[i] = ~seen;
    end
  end

  // Eligible set and lowest-index winner with its vector address
  always_comb begin
    logic found;
    found   = 1'b0;
    winId   = '0;
    elig    = pend & maskReg & prioOk;
    anyElig = |elig;
    for (int i = 0; i < int'(NUM_INTS); i++) begin
      if (elig[i] && !found) begin
        found = 1'b1;
        winId = IdW'(i);
      end
    end
    winAddr = VEC_BASE + (PC_WIDTH'(winId) << VEC_STRIDE_LOG2);
  end

  // Handshake FSM: next state and next registered presentation outputs
  always_comb begin
    stateNext   = state;
    ackFire     = 1'b0;
    pendingNext = 1'b0;
    idNext      = '0;
    addrNext    = '0;
    case (state)
      IDLE: begin
        if (anyElig && !int_disable) begin
          stateNext   = PRESENT;
          pendingNext = 1'b1;
          idNext      = winId;
          addrNext    = winAddr;
        end
      end
      PRESENT: begin
        if (int_ack) begin
          ackFire   = 1'b1;
          stateNext = IDLE;
        end else if (!anyElig || int_disable) begin
          stateNext = IDLE;
        end else begin
          pendingNext = 1'b1;
          idNext      = winId;
          addrNext    = winAddr;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Pending capture: ack clear first, then new edges; level sources just follow the line
  always_comb begin
    pendNext = pend;
    for (int i = 0; i < int'(NUM_INTS); i++) begin
      if (ackFire && (int_id == IdW'(i))) begin
        pendNext[i] = 1'b0;
      end
    end
    pendNext = pendNext | (EDGE_MASK & ints & ~intsPrev);
    pendNext = (pendNext & EDGE_MASK) | (ints & ~EDGE_MASK);
  end

  // In-service stack: isr_done pops the highest level, then an ack pushes the new one
  always_comb begin
    inServiceNext = in_service;
    if (isr_done) begin
      inServiceNext = in_service & (in_service - NUM_INTS'(1));
    end
    for (int i = 0; i < int'(NUM_INTS); i++) begin
      if (ackFire && (int_id == IdW'(i))) begin
        inServiceNext[i] = 1'b1;
      end
    end
  end

  // Mask register update, clear wins over load
  always_comb begin
    maskNext = maskReg;
    if (clr_mask) begin
      maskNext = '0;
    end else if (ld_mask) begin
      maskNext = mask_in;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= '0;
      maskReg     <= '0;
      intsPrev    <= '0;
      in_service  <= '0;
      int_pending <= 1'b0;
      int_id      <= '0;
      int_addr    <= '0;
    end else begin
      pend        <= pendNext;
      maskReg     <= maskNext;
      intsPrev    <= ints;
      in_service  <= inServiceNext;
      int_pending <= pendingNext;
      int_id      <= idNext;
      int_addr    <= addrNext;
    end
  end

endmodule
